// File: rtl/rct_testio_burst_ma.sv
// Serial test-port burst master: bit-serial command in, 1..2^LEN_W mem_if beats, bit-serial response out.
// First request two cycles after PAR; requests stall indefinitely on !ready, each response wait is bounded by TIMEOUT.
module rct_testio_burst_ma #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  test_clk,
  input  logic                  rst_i,
  input  logic                  test_din,
  output logic                  test_dout,
  output logic                  test_doen,
  output logic                  test_intr,
  output logic                  busy_o,
  output logic                  mem_if_req_valid,
  input  logic                  mem_if_req_ready,
  output logic                  mem_if_req_we,
  output logic [ADDR_W-1:0]     mem_if_req_addr,
  output logic [DATA_W/8-1:0]   mem_if_req_strb,
  output logic [DATA_W-1:0]     mem_if_req_wdata,
  input  logic                  mem_if_resp_valid,
  output logic                  mem_if_resp_ready,
  input  logic [DATA_W-1:0]     mem_if_resp_rdata,
  input  logic                  mem_if_resp_err
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BEAT_W  = STRB_W + DATA_W;
  localparam int NBEAT   = 1 << LEN_W;
  localparam int FLD_MAX = (ADDR_W > BEAT_W) ? ADDR_W : BEAT_W;
  localparam int CNT_W   = $clog2(FLD_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_REQ, S_WAIT, S_TX} state_t;
  typedef enum logic [2:0] {F_CMD, F_LEN, F_ADDR, F_BEAT, F_PAR} rx_fld_t;
  typedef enum logic [2:0] {T_ACK, T_DATA, T_PAR, T_STOP, T_END} tx_ph_t;

  state_t              r_state;
  rx_fld_t             r_fld;
  tx_ph_t              r_tph;
  logic                r_cmd;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_beat;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BEAT_W-1:0]   r_wsh;
  logic [BEAT_W-1:0]   r_buf [NBEAT];
  logic                r_par;
  logic                r_tpar;
  logic                r_ack;
  logic [DATA_W-1:0]   r_txw;
  logic [TO_W-1:0]     r_tcnt;
  logic                r_dout;
  logic                r_doen;
  logic                r_intr;
  logic                r_req_vld;
  logic                r_resp_rdy;

  logic                w_last_beat;
  logic [LEN_W-1:0]    w_nxt_beat;
  logic                w_timeout;
  logic                w_go_err;
  logic                w_go_tx;
  logic [BEAT_W-1:0]   w_cur;

  assign w_last_beat = (r_beat == r_len);
  assign w_nxt_beat  = r_beat + 1'b1;
  assign w_timeout   = (r_state == S_WAIT) && !mem_if_resp_valid && (r_tcnt == TO_W'(TIMEOUT - 1));
  assign w_go_err    = ((r_state == S_CHECK) && r_par) ||
                       ((r_state == S_WAIT) && mem_if_resp_valid && mem_if_resp_err) ||
                       w_timeout;
  assign w_go_tx     = w_go_err || ((r_state == S_WAIT) && mem_if_resp_valid && w_last_beat);
  assign w_cur       = r_buf[r_beat];

  assign test_dout         = r_dout;
  assign test_doen         = r_doen;
  assign test_intr         = r_intr;
  assign busy_o            = (r_state != S_IDLE);
  assign mem_if_req_valid  = r_req_vld;
  assign mem_if_req_we     = r_cmd;
  assign mem_if_req_addr   = r_req_addr;
  assign mem_if_req_strb   = r_cmd ? w_cur[BEAT_W-1:DATA_W] : {STRB_W{1'b1}};
  assign mem_if_req_wdata  = r_cmd ? w_cur[DATA_W-1:0] : {DATA_W{1'b0}};
  assign mem_if_resp_ready = r_resp_rdy;

  always_ff @(posedge test_clk) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_fld      <= F_CMD;
      r_tph      <= T_ACK;
      r_cmd      <= 1'b0;
      r_len      <= '0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_req_addr <= '0;
      r_cnt      <= '0;
      r_wsh      <= '0;
      r_par      <= 1'b0;
      r_tpar     <= 1'b0;
      r_ack      <= 1'b0;
      r_txw      <= '0;
      r_tcnt     <= '0;
      r_dout     <= 1'b1;
      r_doen     <= 1'b1;
      r_intr     <= 1'b0;
      r_req_vld  <= 1'b0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_intr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!test_din) begin
            r_state <= S_RX;
            r_fld   <= F_CMD;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_beat  <= '0;
          end
        end
        S_RX: begin
          // Running XOR over CMD..PAR: zero at the end means the frame is intact.
          r_par <= r_par ^ test_din;
          r_cnt <= r_cnt + 1'b1;
          case (r_fld)
            F_CMD: begin
              r_cmd <= test_din;
              r_fld <= F_LEN;
              r_cnt <= '0;
            end
            F_LEN: begin
              r_len <= LEN_W'({r_len, test_din});
              if (r_cnt == CNT_W'(LEN_W - 1)) begin
                r_fld <= F_ADDR;
                r_cnt <= '0;
              end
            end
            F_ADDR: begin
              r_addr <= ADDR_W'({r_addr, test_din});
              if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                r_fld <= r_cmd ? F_BEAT : F_PAR;
                r_cnt <= '0;
              end
            end
            F_BEAT: begin
              r_wsh <= BEAT_W'({r_wsh, test_din});
              if (r_cnt == CNT_W'(BEAT_W - 1)) begin
                r_cnt          <= '0;
                r_buf[r_beat]  <= BEAT_W'({r_wsh, test_din});
                if (w_last_beat) begin
                  r_fld  <= F_PAR;
                  r_beat <= '0;
                end else begin
                  r_beat <= w_nxt_beat;
                end
              end
            end
            F_PAR: r_state <= S_CHECK;
            default: r_fld <= F_CMD;
          endcase
        end
        S_CHECK: begin
          if (!r_par) begin
            r_state    <= S_REQ;
            r_req_vld  <= 1'b1;
            r_req_addr <= r_addr;
            r_beat     <= '0;
          end
        end
        S_REQ: begin
          if (mem_if_req_ready) begin
            r_req_vld  <= 1'b0;
            r_resp_rdy <= 1'b1;
            r_tcnt     <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_if_resp_valid) begin
            if (!mem_if_resp_err && !r_cmd)
              r_buf[r_beat] <= {{STRB_W{1'b0}}, mem_if_resp_rdata};
            if (!mem_if_resp_err && !w_last_beat) begin
              r_beat     <= w_nxt_beat;
              r_req_addr <= r_req_addr + ADDR_W'(STRB_W);
              r_req_vld  <= 1'b1;
              r_resp_rdy <= 1'b0;
              r_state    <= S_REQ;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_TX: begin
          case (r_tph)
            T_ACK: begin
              r_dout <= r_ack;
              r_tpar <= r_ack;
              if (!r_ack && !r_cmd) begin
                r_tph  <= T_DATA;
                r_beat <= '0;
                r_cnt  <= '0;
                r_txw  <= r_buf[0][DATA_W-1:0];
              end else begin
                r_tph <= T_PAR;
              end
            end
            T_DATA: begin
              r_dout <= r_txw[DATA_W-1];
              r_tpar <= r_tpar ^ r_txw[DATA_W-1];
              r_txw  <= r_txw << 1;
              r_cnt  <= r_cnt + 1'b1;
              if (r_cnt == CNT_W'(DATA_W - 1)) begin
                r_cnt <= '0;
                if (w_last_beat) begin
                  r_tph <= T_PAR;
                end else begin
                  r_beat <= w_nxt_beat;
                  r_txw  <= r_buf[w_nxt_beat][DATA_W-1:0];
                end
              end
            end
            T_PAR: begin
              r_dout <= r_tpar;
              r_tph  <= T_STOP;
            end
            T_STOP: begin
              r_dout <= 1'b1;
              r_tph  <= T_END;
            end
            T_END: begin
              r_doen  <= 1'b1;
              r_state <= S_IDLE;
            end
            default: r_tph <= T_ACK;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
      // Every path into TX drives START immediately; the ACK flag picks the frame shape.
      if (w_go_tx) begin
        r_state    <= S_TX;
        r_tph      <= T_ACK;
        r_ack      <= w_go_err;
        r_intr     <= w_go_err;
        r_doen     <= 1'b0;
        r_dout     <= 1'b0;
        r_req_vld  <= 1'b0;
        r_resp_rdy <= 1'b0;
      end
    end
  end

endmodule
